// File: rtl/sector_stat_pkg.sv
// Shared state type, sizing helpers and fill default for the sector statistics snapshot block.
package sector_stat_pkg;

    typedef enum logic [1:0] {IDLE, SEND, CSUM} stream_state_t;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

    function automatic int bytes_per_ch(input int ch_w);
        return ch_w / 8;
    endfunction

    function automatic int total_bytes(input int num_ch, input int ch_w);
        return num_ch * bytes_per_ch(ch_w);
    endfunction

endpackage

// File: rtl/stat_stream_fsm.sv
// Byte-stream sequencer: walks the snapshot bytes, appends an XOR checksum byte,
// and decides on which edge a requested snapshot may be taken.
module stat_stream_fsm
    import sector_stat_pkg::*;
#(
    parameter int TOTAL = 68,
    parameter int IDX_W = $clog2(TOTAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise,
    input  logic             stream_start,
    input  logic             stream_ready,
    input  logic [7:0]       cur_byte,
    output logic [IDX_W-1:0] idx,
    output logic             take_snap,
    output logic             stream_valid,
    output logic [7:0]       stream_data,
    output logic             stream_last,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    stream_state_t state;
    logic [7:0]    checksum;
    logic          pending;

    // Snapshots land either from IDLE or on the edge that hands the FSM back to IDLE.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps a missed branch from inferring a latch.
        take_snap = 1'b0;
        if (state == IDLE) begin
            take_snap = rise;
        end else if (state == CSUM && stream_ready) begin
            take_snap = rise | pending;
        end
    end

    assign stream_data = (state == CSUM) ? checksum : cur_byte;

    // NOTE: non-blocking assignments here so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            checksum     <= '0;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
            busy         <= 1'b0;
            pending      <= 1'b0;
        end else begin
            if (take_snap) begin
                pending <= 1'b0;
            end else if (rise && state != IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (stream_start) begin
                        state        <= SEND;
                        idx          <= '0;
                        checksum     <= '0;
                        busy         <= 1'b1;
                        stream_valid <= 1'b1;
                        stream_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (stream_ready) begin
                        checksum <= checksum ^ cur_byte;
                        if (idx == LAST_IDX) begin
                            state       <= CSUM;
                            stream_last <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (stream_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        stream_valid <= 1'b0;
                        stream_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sector_stat_snapshot.sv
// Coherent snapshot of the sector timing counters, readable by random byte address
// or as a valid/ready byte stream terminated by an XOR checksum.
module sector_stat_snapshot
    import sector_stat_pkg::*;
#(
    parameter int         NUM_CH    = 17,
    parameter int         CH_W      = 32,
    parameter int         ADDR_W    = 15,
    parameter logic [7:0] FILL_BYTE = FILL_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ram_change,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic [ADDR_W-1:0]      address,
    output logic [7:0]             data_CF,
    input  logic                   stream_start,
    output logic                   stream_valid,
    input  logic                   stream_ready,
    output logic [7:0]             stream_data,
    output logic                   stream_last,
    output logic                   busy,
    output logic [7:0]             snap_seq
);

    localparam int BPC   = bytes_per_ch(CH_W);
    localparam int TOTAL = total_bytes(NUM_CH, CH_W);
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int BI_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int TBL_N = 2 ** BI_W;

    if (BPC * 8 != CH_W) begin : g_bad_ch_w
        $error("sector_stat_snapshot: CH_W must be a multiple of 8");
    end
    if (TOTAL > 2 ** (ADDR_W - 1)) begin : g_bad_addr_w
        $error("sector_stat_snapshot: snapshot does not fit the address space");
    end

    logic                   ram_change_d;
    logic                   rise;
    logic                   take_snap;
    logic [NUM_CH*CH_W-1:0] snap;
    logic [IDX_W-1:0]       idx;
    logic [7:0]             byte_tbl [TBL_N];
    logic [ADDR_W-2:0]      rd_index;
    logic                   rd_in_range;

    assign rise = ram_change & ~ram_change_d;

    // Channels are packed little-endian back to back, so byte i sits at flat bit i*8.
    always_comb begin
        for (int i = 0; i < TBL_N; i++) byte_tbl[i] = FILL_BYTE;
        for (int i = 0; i < TOTAL; i++) byte_tbl[i] = snap[i*8 +: 8];
    end

    assign rd_index    = address[ADDR_W-2:0];
    assign rd_in_range = {1'b0, rd_index} < ADDR_W'(TOTAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_change_d <= 1'b0;
            // NOTE: the snapshot store is reset so a read before the first capture returns 0, not X.
            snap         <= '0;
            snap_seq     <= '0;
            data_CF      <= '0;
        end else begin
            ram_change_d <= ram_change;
            if (take_snap) begin
                snap     <= ch_data;
                snap_seq <= snap_seq + 8'd1;
            end
            if (address[ADDR_W-1]) begin
                data_CF <= rd_in_range ? byte_tbl[rd_index[BI_W-1:0]] : FILL_BYTE;
            end
        end
    end

    stat_stream_fsm #(
        .TOTAL (TOTAL),
        .IDX_W (IDX_W)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .rise         (rise),
        .stream_start (stream_start),
        .stream_ready (stream_ready),
        .cur_byte     (byte_tbl[idx[BI_W-1:0]]),
        .idx          (idx),
        .take_snap    (take_snap),
        .stream_valid (stream_valid),
        .stream_data  (stream_data),
        .stream_last  (stream_last),
        .busy         (busy)
    );

endmodule

// File: tb/tb_sector_stat_snapshot.sv
// Directed bench for sector_stat_snapshot: table-driven random reads plus
// hand-written stream sequences with backpressure, mid-stream snapshots and reset.
module tb_sector_stat_snapshot;

    localparam int NUM_CH = 17;
    localparam int CH_W   = 32;
    localparam int ADDR_W = 15;
    localparam int TOTAL  = 68;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ram_change;
    logic [NUM_CH*CH_W-1:0] ch_data;
    logic [ADDR_W-1:0]      address;
    logic [7:0]             data_CF;
    logic                   stream_start;
    logic                   stream_valid;
    logic                   stream_ready;
    logic [7:0]             stream_data;
    logic                   stream_last;
    logic                   busy;
    logic [7:0]             snap_seq;

    logic [31:0] live_ch [NUM_CH];
    logic [31:0] m_ch    [NUM_CH];
    logic [7:0]  exp_seq;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        exp;
    } rd_vec_t;

    rd_vec_t rd_tbl [10];

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) ch_data[k*CH_W +: CH_W] = live_ch[k];
    end

    sector_stat_snapshot #(
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W),
        .ADDR_W    (ADDR_W),
        .FILL_BYTE (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ram_change   (ram_change),
        .ch_data      (ch_data),
        .address      (address),
        .data_CF      (data_CF),
        .stream_start (stream_start),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .stream_data  (stream_data),
        .stream_last  (stream_last),
        .busy         (busy),
        .snap_seq     (snap_seq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int i);
        logic [31:0] w;
        w = m_ch[i / 4];
        return w[8 * (i % 4) +: 8];
    endfunction

    task automatic copy_model();
        for (int k = 0; k < NUM_CH; k++) m_ch[k] = live_ch[k];
    endtask

    task automatic pulse_snapshot();
        ram_change = 1'b1;
        tick();
        ram_change = 1'b0;
        copy_model();
        exp_seq = exp_seq + 8'd1;
        tick();
    endtask

    task automatic rd_check(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        address = a;
        tick();
        check(name, data_CF, exp);
    endtask

    // mode 0: plain stream, mode 1: two snapshot requests mid-stream, mode 2: reset at byte 10
    task automatic stream_run(input int mode, input bit with_rise);
        logic [7:0] exp_b [TOTAL+1];
        logic [7:0] cs;
        int         k;
        int         cyc;
        bit         acc;
        cs = 8'h00;
        for (int i = 0; i < TOTAL; i++) begin
            exp_b[i] = model_byte(i);
            cs       = cs ^ exp_b[i];
        end
        exp_b[TOTAL] = cs;

        stream_start = 1'b1;
        ram_change   = with_rise;
        tick();
        stream_start = 1'b0;
        ram_change   = 1'b0;
        check("start_busy", busy, 1);

        k   = 0;
        cyc = 0;
        while (k <= TOTAL && cyc < 1000) begin
            if (mode == 2 && k == 10) begin
                rst          = 1'b1;
                stream_ready = 1'b0;
                tick();
                rst = 1'b0;
                check("rst_valid", stream_valid, 0);
                check("rst_last", stream_last, 0);
                check("rst_busy", busy, 0);
                check("rst_seq", snap_seq, 0);
                check("rst_data_cf", data_CF, 0);
                return;
            end
            check("s_valid", stream_valid, 1);
            check($sformatf("s_data[%0d]", k), stream_data, exp_b[k]);
            check($sformatf("s_last[%0d]", k), stream_last, (k == TOTAL));
            stream_ready = (cyc % 3 != 2);
            ram_change   = (mode == 1) && (cyc == 15 || cyc == 35);
            acc          = stream_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        stream_ready = 1'b0;
        ram_change   = 1'b0;
        check("s_timeout", (cyc < 1000), 1);
        check("end_busy", busy, 0);
        check("end_valid", stream_valid, 0);
        check("end_last", stream_last, 0);
    endtask

    initial begin
        rd_tbl[0] = '{15'h4000, 8'h44};
        rd_tbl[1] = '{15'h4001, 8'h33};
        rd_tbl[2] = '{15'h4002, 8'h22};
        rd_tbl[3] = '{15'h4003, 8'h11};
        rd_tbl[4] = '{15'h4040, 8'hD0};
        rd_tbl[5] = '{15'h4043, 8'hA0};
        rd_tbl[6] = '{15'h4044, 8'hFF};
        rd_tbl[7] = '{15'h0005, 8'hFF};
        rd_tbl[8] = '{15'h4001, 8'h33};
        rd_tbl[9] = '{15'h0000, 8'h33};

        for (int k = 0; k < NUM_CH; k++) begin
            live_ch[k] = 32'h0;
            m_ch[k]    = 32'h0;
        end
        exp_seq      = 8'd0;
        rst          = 1'b1;
        ram_change   = 1'b0;
        address      = '0;
        stream_start = 1'b0;
        stream_ready = 1'b0;
        repeat (3) tick();
        check("reset_data_cf", data_CF, 0);
        check("reset_seq", snap_seq, 0);
        check("reset_valid", stream_valid, 0);
        check("reset_last", stream_last, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Snapshot, then change live data so reads must come from the frozen copy.
        live_ch[0]  = 32'h11223344;
        live_ch[16] = 32'hA0B0C0D0;
        pulse_snapshot();
        check("seq_after_first", snap_seq, exp_seq);
        live_ch[0] = 32'hDEADBEEF;

        begin
            logic [7:0] prev;
            prev = data_CF;
            for (int i = 0; i < 10; i++) begin
                address = rd_tbl[i].addr;
                #1;
                check($sformatf("rd_latency[%0d]", i), data_CF, prev);
                tick();
                check($sformatf("rd[%0d]", i), data_CF, rd_tbl[i].exp);
                prev = rd_tbl[i].exp;
            end
        end

        // Stream the documented pattern with backpressure.
        live_ch[0]  = 32'h11223344;
        live_ch[16] = 32'h0;
        pulse_snapshot();
        check("seq_second", snap_seq, exp_seq);
        repeat (256) pulse_snapshot();
        check("seq_wrap", snap_seq, exp_seq);
        stream_run(0, 1'b0);

        // Snapshot requests during a stream collapse into one, taken at the return to IDLE.
        live_ch[0] = 32'h00000055;
        stream_run(1, 1'b0);
        copy_model();
        exp_seq = exp_seq + 8'd1;
        check("seq_pending", snap_seq, exp_seq);
        rd_check("rd_pending_b0", 15'h4000, 8'h55);
        rd_check("rd_pending_b1", 15'h4001, 8'h00);

        // Reset part-way through a stream.
        stream_run(2, 1'b0);
        exp_seq = 8'd0;
        for (int k = 0; k < NUM_CH; k++) m_ch[k] = 32'h0;
        rd_check("rd_after_rst", 15'h4000, 8'h00);

        // Rise and stream_start together: the stream carries the new snapshot.
        live_ch[0] = 32'h000000AB;
        copy_model();
        stream_run(0, 1'b1);
        exp_seq = exp_seq + 8'd1;
        check("seq_simul", snap_seq, exp_seq);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
